// File: rtl/pixie_pkg.sv
// pixie_pkg -- shared constants and types for the Pixie (CDP1861-style)
// framebuffer: default raster timing, buffer geometry, colour values and the
// per-pixel control word carried through the scanout pipeline.
package pixie_pkg;

  // Default raster timing (ce_pix ticks / lines)
  localparam int H_TOTAL_DEF  = 384;
  localparam int H_ACTIVE_DEF = 256;
  localparam int HS_START_DEF = 288;
  localparam int HS_WIDTH_DEF = 32;
  localparam int V_TOTAL_DEF  = 312;
  localparam int V_ACTIVE_DEF = 256;
  localparam int VS_START_DEF = 272;
  localparam int VS_WIDTH_DEF = 3;

  // Buffer geometry: 128 lines x 8 bytes
  localparam int FB_DEPTH = 1024;
  localparam int FB_AW    = 10;

  // Raster counter width; covers totals up to 512
  localparam int CNT_W = 9;

  // Colour levels
  localparam logic [7:0] COLOR_ON  = 8'hFF;
  localparam logic [7:0] COLOR_DIM = 8'h80;
  localparam logic [7:0] COLOR_OFF = 8'h00;

  // 1802 state code for a DMA cycle
  localparam logic [1:0] SC_DMA = 2'd2;

  // Control word captured alongside each raster position
  typedef struct packed {
    logic de;
    logic hblank;
    logic vblank;
    logic hsync;
    logic vsync;
    logic load;   // first tick of a new source byte
    logic shift;  // first tick of a new source pixel
    logic odd;    // odd output line
  } pix_ctl_t;

  localparam pix_ctl_t CTL_RESET = '{de: 1'b0, hblank: 1'b1, vblank: 1'b1,
                                     hsync: 1'b0, vsync: 1'b0, load: 1'b0,
                                     shift: 1'b0, odd: 1'b0};

  // True when start <= cnt < start + width (evaluated one bit wider so the
  // end of the window cannot overflow)
  function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                     input logic [CNT_W-1:0] start,
                                     input logic [CNT_W-1:0] width);
    return ({1'b0, cnt} >= {1'b0, start}) &&
           ({1'b0, cnt} <  ({1'b0, start} + {1'b0, width}));
  endfunction

endpackage

// File: rtl/pixie_fb_ram.sv
// pixie_fb_ram -- 1024x8 simple dual-port display buffer.
// Ports:
//   i_clock            : clock for both ports
//   i_we, i_waddr,
//   i_wdata            : write port
//   i_raddr, o_rdata   : registered read port (1 clock latency)
// A read of the address being written in the same clock returns the old data.
// Contents are not reset.
module pixie_fb_ram
  import pixie_pkg::*;
(
  input  logic             i_clock,
  input  logic             i_we,
  input  logic [FB_AW-1:0] i_waddr,
  input  logic [7:0]       i_wdata,
  input  logic [FB_AW-1:0] i_raddr,
  output logic [7:0]       o_rdata
);

  logic [7:0] r_mem [FB_DEPTH];

  // Write port plus registered read; the read samples pre-write contents
  always_ff @(posedge i_clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/pixie_framebuffer.sv
// pixie_framebuffer -- captures 1802 DMA display bytes into a 1024x8 buffer
// and scans it out as a 64x128 monochrome image, each source pixel shown
// 4 ticks wide and each source line shown twice.
// Ports:
//   clock, reset (sync, active-low), ce_pix (pixel-clock enable)
//   TPB, SC[1:0], DataIn[7:0]  : 1802 DMA capture (write on SC==2, first TPB clock)
//   INT                        : 1861 interrupt; its rising edge rewinds the write pointer
//   R/G/B[7:0], HSync, VSync, HBlank, VBlank, DE : video out, 2 ce_pix ticks behind counters
// Build option: define PIXIE_SCANLINES_EN to dim lit pixels on odd output lines.
module pixie_framebuffer
  import pixie_pkg::*;
#(
  parameter int H_TOTAL  = H_TOTAL_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int HS_START = HS_START_DEF,
  parameter int HS_WIDTH = HS_WIDTH_DEF,
  parameter int V_TOTAL  = V_TOTAL_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int VS_START = VS_START_DEF,
  parameter int VS_WIDTH = VS_WIDTH_DEF
)(
  input  logic       clock,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic       TPB,
  input  logic [1:0] SC,
  input  logic [7:0] DataIn,
  input  logic       INT,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B,
  output logic       HSync,
  output logic       VSync,
  output logic       HBlank,
  output logic       VBlank,
  output logic       DE
);

  localparam logic [CNT_W-1:0] LP_H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] LP_V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] LP_H_ACTIVE = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] LP_V_ACTIVE = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] LP_HS_START = CNT_W'(HS_START);
  localparam logic [CNT_W-1:0] LP_HS_WIDTH = CNT_W'(HS_WIDTH);
  localparam logic [CNT_W-1:0] LP_VS_START = CNT_W'(VS_START);
  localparam logic [CNT_W-1:0] LP_VS_WIDTH = CNT_W'(VS_WIDTH);

`ifdef PIXIE_SCANLINES_EN
  localparam logic LP_SCANLINES = 1'b1;
`else
  localparam logic LP_SCANLINES = 1'b0;
`endif

  // ---------------- capture side (runs every clock) ----------------
  logic             r_tpb_d;
  logic             r_int_d;
  logic             r_int_rise;
  logic [FB_AW-1:0] r_wr_addr;
  logic             w_we;

  // Only the first high clock of a TPB pulse can write, and never in reset
  assign w_we = reset && (SC == SC_DMA) && TPB && !r_tpb_d;

  // TPB/INT edge detection and write pointer; the registered INT edge
  // rewinds the pointer one clock later, overriding any increment
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_tpb_d    <= 1'b0;
      r_int_d    <= 1'b1;
      r_int_rise <= 1'b0;
      r_wr_addr  <= {FB_AW{1'b0}};
    end else begin
      r_tpb_d    <= TPB;
      r_int_d    <= INT;
      r_int_rise <= INT && !r_int_d;
      if (r_int_rise) begin
        r_wr_addr <= {FB_AW{1'b0}};
      end else if (w_we) begin
        r_wr_addr <= r_wr_addr + FB_AW'(1);
      end else begin
        r_wr_addr <= r_wr_addr;
      end
    end
  end

  // ---------------- scanout side (advances on ce_pix) ----------------
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_vcnt;
  logic             w_h_last;
  logic             w_v_last;
  logic [FB_AW-1:0] w_rd_addr;
  logic [7:0]       w_rd_data;

  assign w_h_last = (r_hcnt == LP_H_LAST);
  assign w_v_last = (r_vcnt == LP_V_LAST);

  // Source byte: line = vcnt[7:1], byte column = hcnt[7:5]
  assign w_rd_addr = {r_vcnt[7:1], r_hcnt[7:5]};

  // Raster counters
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_hcnt <= {CNT_W{1'b0}};
      r_vcnt <= {CNT_W{1'b0}};
    end else if (ce_pix) begin
      if (w_h_last) begin
        r_hcnt <= {CNT_W{1'b0}};
        r_vcnt <= w_v_last ? {CNT_W{1'b0}} : (r_vcnt + CNT_W'(1));
      end else begin
        r_hcnt <= r_hcnt + CNT_W'(1);
        r_vcnt <= r_vcnt;
      end
    end else begin
      r_hcnt <= r_hcnt;
      r_vcnt <= r_vcnt;
    end
  end

  pixie_fb_ram u_ram (
    .i_clock (clock),
    .i_we    (w_we),
    .i_waddr (r_wr_addr),
    .i_wdata (DataIn),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  // Stage 1 control word from the current raster position
  pix_ctl_t w_ctl;
  logic     w_h_act;
  logic     w_v_act;

  assign w_h_act = (r_hcnt < LP_H_ACTIVE);
  assign w_v_act = (r_vcnt < LP_V_ACTIVE);

  // Timing decode for the current counter position
  always_comb begin
    w_ctl        = CTL_RESET;
    w_ctl.de     = w_h_act && w_v_act;
    w_ctl.hblank = !w_h_act;
    w_ctl.vblank = !w_v_act;
    w_ctl.hsync  = in_window(r_hcnt, LP_HS_START, LP_HS_WIDTH);
    w_ctl.vsync  = in_window(r_vcnt, LP_VS_START, LP_VS_WIDTH);
    w_ctl.load   = (r_hcnt[4:0] == 5'd0);
    w_ctl.shift  = (r_hcnt[1:0] == 2'd0);
    w_ctl.odd    = r_vcnt[0];
  end

  // Stage 2: pixel shifter. The buffer word read for a byte boundary is
  // ready one ce_pix tick later; every 4th tick moves to the next pixel.
  pix_ctl_t   r_ctl;
  logic [7:0] r_shift;
  logic [7:0] w_shift_next;
  logic       w_lit;
  logic [7:0] w_lit_colour;
  logic [7:0] w_pix;

  // Shifter next-state and current pixel bit
  always_comb begin
    w_shift_next = r_shift;
    w_lit        = r_shift[7];
    if (r_ctl.load) begin
      w_shift_next = w_rd_data;
      w_lit        = w_rd_data[7];
    end else if (r_ctl.shift) begin
      w_shift_next = {r_shift[6:0], 1'b0};
      w_lit        = r_shift[6];
    end else begin
      w_shift_next = r_shift;
      w_lit        = r_shift[7];
    end
  end

  assign w_lit_colour = (LP_SCANLINES && r_ctl.odd) ? COLOR_DIM : COLOR_ON;
  assign w_pix        = (r_ctl.de && w_lit) ? w_lit_colour : COLOR_OFF;

  // Pipeline and output registers; everything holds while ce_pix is low
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ctl   <= CTL_RESET;
      r_shift <= 8'h00;
      R       <= COLOR_OFF;
      G       <= COLOR_OFF;
      B       <= COLOR_OFF;
      HSync   <= 1'b0;
      VSync   <= 1'b0;
      HBlank  <= 1'b1;
      VBlank  <= 1'b1;
      DE      <= 1'b0;
    end else if (ce_pix) begin
      r_ctl   <= w_ctl;
      r_shift <= w_shift_next;
      R       <= w_pix;
      G       <= w_pix;
      B       <= w_pix;
      HSync   <= r_ctl.hsync;
      VSync   <= r_ctl.vsync;
      HBlank  <= r_ctl.hblank;
      VBlank  <= r_ctl.vblank;
      DE      <= r_ctl.de;
    end else begin
      r_ctl   <= r_ctl;
      r_shift <= r_shift;
    end
  end

endmodule
